// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, register-file entry
// layout, FSM states and the 16-bit wrap-around step helper.
package ex_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_DEC   = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_LEFT  = 3'd4;

    localparam int RF_ENTRY_W = 35;
    localparam int RF_VALID   = 34;
    localparam int RF_LOCK    = 33;
    localparam int RF_DIRTY   = 32;
    localparam int RF_PTR_LSB = 16;
    localparam int RF_VAL_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } ex_state_e;

    // Add or subtract one, wrapping modulo 2^16.
    function automatic logic [15:0] step16(input logic [15:0] v, input logic up);
        return up ? (v + 16'd1) : (v - 16'd1);
    endfunction

endpackage

// File: rtl/ex_if.sv
// Data-memory request/acknowledge channel between ex (master) and memory (slave).
interface ex_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/ex_rf_sel.sv
// Extracts one core's 35-bit cell entry from the flat register-file bus.
// Shared with wb; an id with no matching core reads as an empty entry.
module ex_rf_sel
    import ex_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int CORE_W = 2
) (
    input  logic [NCORES*RF_ENTRY_W-1:0] rf,
    input  logic [CORE_W-1:0]            core,
    output logic [RF_ENTRY_W-1:0]        entry
);

    // OR together the masked entries; at most one core id matches.
    always_comb begin
        entry = {RF_ENTRY_W{1'b0}};
        for (int i = 0; i < NCORES; i++) begin
            entry = entry | ((core == CORE_W'(i)) ? rf[i*RF_ENTRY_W +: RF_ENTRY_W]
                                                   : {RF_ENTRY_W{1'b0}});
        end
    end

endmodule

// File: rtl/ex.sv
// Execute stage: applies cell/pointer ops to a core's cached cell, spilling
// and filling through the data-memory channel, and hands results to wb.
module ex
    import ex_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int CORE_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    input  logic [2:0]                   instr_op,
    input  logic [CORE_W-1:0]            instr_core,
    output logic                         instr_ready,
    input  logic [NCORES*RF_ENTRY_W-1:0] rf_in,
    ex_if.master                         mem,
    output logic                         wb_en_out,
    output logic [CORE_W-1:0]            core_out,
    output logic [15:0]                  val_out,
    output logic [15:0]                  ptr_out,
    output logic                         dirty_out
);

    logic [RF_ENTRY_W-1:0] sel_entry_s;
    logic                  accept_s;
    logic                  ack_s;

    ex_state_e        state_r, state_s;
    logic [2:0]       op_r, op_s;
    logic [CORE_W-1:0] core_r, core_s;
    logic [15:0]      ptr_r, ptr_s;
    logic [15:0]      nptr_r, nptr_s;

    logic             mem_req_r, mem_req_s;
    logic             mem_we_r, mem_we_s;
    logic [15:0]      mem_addr_r, mem_addr_s;
    logic [15:0]      mem_wdata_r, mem_wdata_s;

    logic             wb_en_r, wb_en_s;
    logic [CORE_W-1:0] core_out_r, core_out_s;
    logic [15:0]      val_out_r, val_out_s;
    logic [15:0]      ptr_out_r, ptr_out_s;
    logic             dirty_out_r, dirty_out_s;

    ex_rf_sel #(.NCORES(NCORES), .CORE_W(CORE_W)) u_rf_sel (
        .rf    (rf_in),
        .core  (instr_core),
        .entry (sel_entry_s)
    );

    // A locked entry still has a result in flight, so hold the instruction off.
    assign instr_ready = (state_r == ST_IDLE) && !sel_entry_s[RF_LOCK] && !rst;
    assign accept_s    = instr_valid && instr_ready;
    // An acknowledge only counts while a request is actually outstanding.
    assign ack_s       = mem.mem_ack && mem_req_r;

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;

    assign wb_en_out = wb_en_r;
    assign core_out  = core_out_r;
    assign val_out   = val_out_r;
    assign ptr_out   = ptr_out_r;
    assign dirty_out = dirty_out_r;

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        core_s      = core_r;
        ptr_s       = ptr_r;
        nptr_s      = nptr_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        wb_en_s     = 1'b0;
        core_out_s  = core_out_r;
        val_out_s   = val_out_r;
        ptr_out_s   = ptr_out_r;
        dirty_out_s = dirty_out_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op_s   = instr_op;
                    core_s = instr_core;
                    ptr_s  = sel_entry_s[RF_PTR_LSB +: 16];
                    nptr_s = step16(sel_entry_s[RF_PTR_LSB +: 16], instr_op == OP_RIGHT);
                    case (instr_op)
                        OP_INC, OP_DEC: begin
                            if (sel_entry_s[RF_VALID]) begin
                                state_s     = ST_DONE;
                                wb_en_s     = 1'b1;
                                core_out_s  = instr_core;
                                val_out_s   = step16(sel_entry_s[RF_VAL_LSB +: 16],
                                                     instr_op == OP_INC);
                                ptr_out_s   = sel_entry_s[RF_PTR_LSB +: 16];
                                dirty_out_s = 1'b1;
                            end else begin
                                state_s    = ST_FILL;
                                mem_req_s  = 1'b1;
                                mem_we_s   = 1'b0;
                                mem_addr_s = sel_entry_s[RF_PTR_LSB +: 16];
                            end
                        end
                        OP_RIGHT, OP_LEFT: begin
                            if (sel_entry_s[RF_VALID] && sel_entry_s[RF_DIRTY]) begin
                                state_s     = ST_SPILL;
                                mem_req_s   = 1'b1;
                                mem_we_s    = 1'b1;
                                mem_addr_s  = sel_entry_s[RF_PTR_LSB +: 16];
                                mem_wdata_s = sel_entry_s[RF_VAL_LSB +: 16];
                            end else begin
                                state_s    = ST_FILL;
                                mem_req_s  = 1'b1;
                                mem_we_s   = 1'b0;
                                mem_addr_s = step16(sel_entry_s[RF_PTR_LSB +: 16],
                                                    instr_op == OP_RIGHT);
                            end
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SPILL: begin
                if (ack_s) begin
                    state_s    = ST_FILL;
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = nptr_r;
                end else begin
                    state_s = ST_SPILL;
                end
            end
            ST_FILL: begin
                if (ack_s) begin
                    state_s    = ST_DONE;
                    mem_req_s  = 1'b0;
                    mem_we_s   = 1'b0;
                    wb_en_s    = 1'b1;
                    core_out_s = core_r;
                    if ((op_r == OP_RIGHT) || (op_r == OP_LEFT)) begin
                        val_out_s   = mem.mem_rdata;
                        ptr_out_s   = nptr_r;
                        dirty_out_s = 1'b0;
                    end else begin
                        val_out_s   = step16(mem.mem_rdata, op_r == OP_INC);
                        ptr_out_s   = ptr_r;
                        dirty_out_s = 1'b1;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Register state and all outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_NOP;
            core_r      <= {CORE_W{1'b0}};
            ptr_r       <= 16'h0000;
            nptr_r      <= 16'h0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
            wb_en_r     <= 1'b0;
            core_out_r  <= {CORE_W{1'b0}};
            val_out_r   <= 16'h0000;
            ptr_out_r   <= 16'h0000;
            dirty_out_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            core_r      <= core_s;
            ptr_r       <= ptr_s;
            nptr_r      <= nptr_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            wb_en_r     <= wb_en_s;
            core_out_r  <= core_out_s;
            val_out_r   <= val_out_s;
            ptr_out_r   <= ptr_out_s;
            dirty_out_r <= dirty_out_s;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the execute stage.
module tb_ex;
    import ex_pkg::*;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [2:0]  instr_op;
    logic [1:0]  instr_core;
    logic        instr_ready;
    logic [4*35-1:0] rf_in;
    logic        wb_en_out;
    logic [1:0]  core_out;
    logic [15:0] val_out;
    logic [15:0] ptr_out;
    logic        dirty_out;

    logic [34:0] rf_arr [4];
    assign rf_in = {rf_arr[3], rf_arr[2], rf_arr[1], rf_arr[0]};

    ex_if mem_bus ();

    ex #(.NCORES(4), .CORE_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_op    (instr_op),
        .instr_core  (instr_core),
        .instr_ready (instr_ready),
        .rf_in       (rf_in),
        .mem         (mem_bus),
        .wb_en_out   (wb_en_out),
        .core_out    (core_out),
        .val_out     (val_out),
        .ptr_out     (ptr_out),
        .dirty_out   (dirty_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int req_cnt = 0;
    int wb_cnt = 0;

    // Count handshakes, request cycles and result pulses.
    always @(posedge clk) begin
        if (mem_bus.mem_req && mem_bus.mem_ack) hs_cnt <= hs_cnt + 1;
        if (mem_bus.mem_req) req_cnt <= req_cnt + 1;
        if (wb_en_out) wb_cnt <= wb_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] mk(input logic v, input logic l, input logic d,
                                       input logic [15:0] p, input logic [15:0] x);
        return {v, l, d, p, x};
    endfunction

    task automatic check_wb(input string tag, input logic [1:0] c, input logic [15:0] v,
                            input logic [15:0] p, input logic d);
        check_val({tag, ".wb_en"}, 32'(wb_en_out), 32'd1);
        check_val({tag, ".core"},  32'(core_out),  32'(c));
        check_val({tag, ".val"},   32'(val_out),   32'(v));
        check_val({tag, ".ptr"},   32'(ptr_out),   32'(p));
        check_val({tag, ".dirty"}, 32'(dirty_out), 32'(d));
    endtask

    task automatic check_req(input string tag, input logic we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic chk_wdata);
        check_val({tag, ".req"},  32'(mem_bus.mem_req),  32'd1);
        check_val({tag, ".we"},   32'(mem_bus.mem_we),   32'(we));
        check_val({tag, ".addr"}, 32'(mem_bus.mem_addr), 32'(addr));
        if (chk_wdata) check_val({tag, ".wdata"}, 32'(mem_bus.mem_wdata), 32'(wdata));
    endtask

    // Entered in the first cycle a request is visible; acks in cycle n.
    task automatic serve(input int n, input logic [15:0] rd);
        for (int i = 1; i < n; i++) tick();
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = rd;
        tick();
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
    endtask

    int hs0, req0, wb0;

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op = OP_NOP;
        instr_core = 2'd0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        for (int i = 0; i < 4; i++) rf_arr[i] = 35'd0;

        // Reset values
        tick(); tick();
        check_val("rst.wb_en", 32'(wb_en_out), 32'd0);
        check_val("rst.req", 32'(mem_bus.mem_req), 32'd0);
        check_val("rst.we", 32'(mem_bus.mem_we), 32'd0);
        check_val("rst.ready", 32'(instr_ready), 32'd0);
        check_val("rst.val", 32'(val_out), 32'd0);
        check_val("rst.ptr", 32'(ptr_out), 32'd0);
        check_val("rst.addr", 32'(mem_bus.mem_addr), 32'd0);
        check_val("rst.wdata", 32'(mem_bus.mem_wdata), 32'd0);
        check_val("rst.core", 32'(core_out), 32'd0);
        check_val("rst.dirty", 32'(dirty_out), 32'd0);
        rst = 1'b0;
        tick();

        // Core 1 valid INC: latency 1, no memory traffic
        rf_arr[1] = mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0041);
        req0 = req_cnt;
        instr_valid = 1'b1; instr_op = OP_INC; instr_core = 2'd1;
        #1;
        check_val("inc.ready", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        check_wb("inc", 2'd1, 16'h0042, 16'h0010, 1'b1);
        check_val("inc.ready_done", 32'(instr_ready), 32'd0);
        tick();
        check_val("inc.pulse_end", 32'(wb_en_out), 32'd0);
        check_val("inc.hold_val", 32'(val_out), 32'h0042);
        check_val("inc.no_req", 32'(req_cnt - req0), 32'd0);

        // Core 0 dirty RIGHT at 0xFFFF: spill then fill at wrapped pointer
        rf_arr[0] = mk(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0005);
        hs0 = hs_cnt; wb0 = wb_cnt;
        instr_valid = 1'b1; instr_op = OP_RIGHT; instr_core = 2'd0;
        tick();
        instr_valid = 1'b0;
        check_req("right.spill", 1'b1, 16'hFFFF, 16'h0005, 1'b1);
        tick();
        check_req("right.spill_hold", 1'b1, 16'hFFFF, 16'h0005, 1'b1);
        tick();
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check_req("right.fill", 1'b0, 16'h0000, 16'h0000, 1'b0);
        check_val("right.no_wb_yet", 32'(wb_cnt - wb0), 32'd0);
        serve(3, 16'h0077);
        check_wb("right", 2'd0, 16'h0077, 16'h0000, 1'b0);
        check_val("right.req_drop", 32'(mem_bus.mem_req), 32'd0);
        check_val("right.hs", 32'(hs_cnt - hs0), 32'd2);
        tick();

        // Core 2 invalid DEC: fill at 0 with same-cycle ack, result wraps
        rf_arr[2] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234);
        hs0 = hs_cnt;
        instr_valid = 1'b1; instr_op = OP_DEC; instr_core = 2'd2;
        tick();
        instr_valid = 1'b0;
        check_req("dec.fill", 1'b0, 16'h0000, 16'h0000, 1'b0);
        serve(1, 16'h0000);
        check_wb("dec", 2'd2, 16'hFFFF, 16'h0000, 1'b1);
        check_val("dec.hs", 32'(hs_cnt - hs0), 32'd1);
        tick();

        // Core 3 locked: held off until lock clears, then LEFT fills at 0xFFFF
        rf_arr[3] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        hs0 = hs_cnt;
        instr_valid = 1'b1; instr_op = OP_LEFT; instr_core = 2'd3;
        #1;
        check_val("lock.ready0", 32'(instr_ready), 32'd0);
        tick(); tick();
        check_val("lock.ready1", 32'(instr_ready), 32'd0);
        check_val("lock.no_req", 32'(mem_bus.mem_req), 32'd0);
        rf_arr[3] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
        #1;
        check_val("lock.ready_clear", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        check_req("left.fill", 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        serve(2, 16'h00AB);
        check_wb("left", 2'd3, 16'h00AB, 16'hFFFF, 1'b0);
        check_val("left.hs", 32'(hs_cnt - hs0), 32'd1);
        tick();

        // Reset during FILL abandons the transaction
        rf_arr[2] = mk(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
        wb0 = wb_cnt;
        instr_valid = 1'b1; instr_op = OP_INC; instr_core = 2'd2;
        tick();
        instr_valid = 1'b0;
        check_req("rstfill.req", 1'b0, 16'h0100, 16'h0000, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("rstfill.req_drop", 32'(mem_bus.mem_req), 32'd0);
        check_val("rstfill.idle", 32'(instr_ready), 32'd1);
        tick(); tick();
        check_val("rstfill.no_wb", 32'(wb_cnt - wb0), 32'd0);
        instr_valid = 1'b1; instr_op = OP_INC; instr_core = 2'd1;
        tick();
        instr_valid = 1'b0;
        check_wb("rstfill.inc", 2'd1, 16'h0042, 16'h0010, 1'b1);
        tick();

        // NOP, op 6 and a stray ack: no traffic, no result; INC still latency 1
        req0 = req_cnt; wb0 = wb_cnt;
        instr_valid = 1'b1; instr_op = OP_NOP; instr_core = 2'd1;
        #1;
        check_val("nop.ready", 32'(instr_ready), 32'd1);
        tick();
        instr_op = 3'd6;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 16'hBEEF;
        #1;
        check_val("op6.ready", 32'(instr_ready), 32'd1);
        tick();
        mem_bus.mem_ack = 1'b0;
        check_val("op6.no_wb", 32'(wb_en_out), 32'd0);
        instr_op = OP_DEC;
        tick();
        instr_valid = 1'b0;
        check_wb("nop.dec", 2'd1, 16'h0040, 16'h0010, 1'b1);
        check_val("nop.no_req", 32'(req_cnt - req0), 32'd0);
        tick();
        check_val("nop.one_wb", 32'(wb_cnt - wb0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
